// File: rtl/tick_sched.sv
// tick_sched: shared time-base scheduler.
// A free-running prescaler produces a base strobe every PRE_DIV clocks. Four
// independent channels divide that strobe by a programmable divisor and each
// emit one-clock periodic ticks while in RUN.
// Optional feature macro: TICK_SCHED_ONESHOT_EN adds a per-channel oneshot
// input; a channel started with oneshot set ticks once and returns to IDLE.
// Control inputs (wr_en, start, stop) are plain level-sampled strobes: there
// is no valid/ready back-pressure; every input is acted on at the edge where
// it is sampled, and busy reflects each channel's FSM state (1 = RUN).
module tick_sched #(
    parameter int PRE_DIV = 50000,
    parameter int DIV_W   = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             wr_en,
    input  logic [1:0]       wr_ch,
    input  logic [DIV_W-1:0] wr_div,
    input  logic [3:0]       start,
    input  logic [3:0]       stop,
`ifdef TICK_SCHED_ONESHOT_EN
    input  logic [3:0]       oneshot,
`endif
    output logic [3:0]       tick,
    output logic [3:0]       busy,
    output logic             cfg_err
);

    localparam int PRE_W = $clog2(PRE_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             strb;
    logic [DIV_W-1:0] div_q [4];
    logic [DIV_W-1:0] div_d [4];
    logic [DIV_W-1:0] cnt_q [4];
    logic [DIV_W-1:0] cnt_d [4];
    ch_state_e        state_q [4];
    ch_state_e        state_d [4];
    logic [3:0]       tick_q, tick_d;
    logic             cfg_err_q, cfg_err_d;
`ifdef TICK_SCHED_ONESHOT_EN
    logic [3:0]       oneshot_q, oneshot_d;
`endif

    // Prescaler: counts enabled clocks, strobe on the last count of each lap
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (en) begin
            pre_cnt_d = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + PRE_W'(1);
        end
        strb = en && (pre_cnt_q == PRE_LAST);
    end

    // Divisor file: a same-cycle write is visible to start/reload decisions
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            div_d[i] = (wr_en && (wr_ch == 2'(i))) ? wr_div : div_q[i];
        end
    end

    // Channel FSMs: next state, count, tick and configuration error
    always_comb begin
        tick_d    = '0;
        cfg_err_d = 1'b0;
`ifdef TICK_SCHED_ONESHOT_EN
        oneshot_d = oneshot_q;
`endif
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (state_q[i] == ST_IDLE) begin
                if (start[i]) begin
                    if (div_d[i] == '0) begin
                        // Refused: nothing to count down from
                        cfg_err_d = 1'b1;
                    end else if (!stop[i]) begin
                        state_d[i] = ST_RUN;
                        cnt_d[i]   = div_d[i] - DIV_W'(1);
`ifdef TICK_SCHED_ONESHOT_EN
                        oneshot_d[i] = oneshot[i];
`endif
                    end
                end
            end else begin
                if (stop[i]) begin
                    // Stop beats both a same-cycle start and an expiry
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end else if (strb) begin
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - DIV_W'(1);
                    end else begin
                        tick_d[i] = 1'b1;
`ifdef TICK_SCHED_ONESHOT_EN
                        if ((div_d[i] == '0) || oneshot_q[i]) begin
`else
                        if (div_d[i] == '0) begin
`endif
                            // Divisor cleared (or single shot): retire after this tick
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = div_d[i] - DIV_W'(1);
                        end
                    end
                end
            end
        end
    end

    // State registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            pre_cnt_q <= '0;
            tick_q    <= '0;
            cfg_err_q <= 1'b0;
`ifdef TICK_SCHED_ONESHOT_EN
            oneshot_q <= '0;
`endif
            for (int i = 0; i < 4; i++) begin
                div_q[i]   <= '0;
                cnt_q[i]   <= '0;
                state_q[i] <= ST_IDLE;
            end
        end else begin
            pre_cnt_q <= pre_cnt_d;
            tick_q    <= tick_d;
            cfg_err_q <= cfg_err_d;
`ifdef TICK_SCHED_ONESHOT_EN
            oneshot_q <= oneshot_d;
`endif
            for (int i = 0; i < 4; i++) begin
                div_q[i]   <= div_d[i];
                cnt_q[i]   <= cnt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    // Outputs: busy mirrors the per-channel FSM state
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            busy[i] = (state_q[i] == ST_RUN);
        end
        tick    = tick_q;
        cfg_err = cfg_err_q;
    end

endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: scenario tasks for tick_sched (PRE_DIV=4, DIV_W=8).
// Expected tick edges are computed from the bench's own prescaler phase and
// pushed as {channel, edge} into exp_q; the negedge monitor removes matches.
module tb_tick_sched;

    localparam int PRE_DIV = 4;
    localparam int DIV_W   = 8;

    logic             clk;
    logic             clr;
    logic             en;
    logic             wr_en;
    logic [1:0]       wr_ch;
    logic [DIV_W-1:0] wr_div;
    logic [3:0]       start;
    logic [3:0]       stop;
`ifdef TICK_SCHED_ONESHOT_EN
    logic [3:0]       oneshot;
`endif
    logic [3:0]       tick;
    logic [3:0]       busy;
    logic             cfg_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;   // index of the most recent posedge
    int ph     = 0;   // prescaler value that the next edge will sample
    logic [31:0] exp_q[$];

    tick_sched #(.PRE_DIV(PRE_DIV), .DIV_W(DIV_W)) dut (
        .clk     (clk),
        .clr     (clr),
        .en      (en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .start   (start),
        .stop    (stop),
`ifdef TICK_SCHED_ONESHOT_EN
        .oneshot (oneshot),
`endif
        .tick    (tick),
        .busy    (busy),
        .cfg_err (cfg_err)
    );

    // Clock and edge/phase bookkeeping
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr) ph <= 0;
        else if (en) ph <= (ph == PRE_DIV - 1) ? 0 : ph + 1;
    end

    // Scoreboard monitor: every observed tick must match a queued expectation
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (tick[c] === 1'b1) begin
                logic [31:0] key;
                int idx;
                key = {2'(c), 30'(cyc)};
                idx = -1;
                for (int k = 0; k < exp_q.size(); k++) begin
                    if (exp_q[k] == key) idx = k;
                end
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL tick_sb ch%0d: tick seen after edge %0d, none expected", c, cyc);
                end else begin
                    exp_q.delete(idx);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int edge_n);
        while (cyc < edge_n) step();
    endtask

    // Edge of the k-th strobe strictly after the next edge, en held at 1
    function automatic int next_strobe(input int k);
        int s, p1;
        s  = cyc + 1;
        p1 = (ph + 1) % PRE_DIV;
        return s + 1 + (PRE_DIV - 1 - p1) + PRE_DIV * (k - 1);
    endfunction

    task automatic push_tick(input int ch, input int edge_n);
        exp_q.push_back({2'(ch), 30'(edge_n)});
    endtask

    task automatic test_reset();
        clr = 1'b1; en = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
        start = '0; stop = '0;
`ifdef TICK_SCHED_ONESHOT_EN
        oneshot = '0;
`endif
        step();
        step();
        clr = 1'b0;
        checks++; if (tick !== 4'b0000) begin errors++; $display("FAIL reset_tick: got %b want 0000", tick); end
        checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL reset_busy: got %b want 0000", busy); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    endtask

    task automatic test_cfg_err();
        start = 4'b0100;
        step();
        start = '0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse: got %b want 1", cfg_err); end
        checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL cfg_err_busy: got %b want 0", busy[2]); end
        step();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_width: got %b want 0", cfg_err); end
    endtask

    task automatic test_periodic();
        int t1;
        // Same-cycle write and start: start must see div=3
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd3; start = 4'b0001;
        t1 = next_strobe(3);
        push_tick(0, t1); push_tick(0, t1 + 12); push_tick(0, t1 + 24);
        step();
        wr_en = 1'b0; start = '0;
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL periodic_busy: got %b want 1", busy[0]); end
        run_to(t1 + 25);
        stop = 4'b0001;
        step();
        stop = '0;
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL periodic_stop_busy: got %b want 0", busy[0]); end
        run_to(cyc + 30);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL periodic_missing: %0d ticks outstanding, want 0", exp_q.size()); end
    endtask

    task automatic test_rewrite();
        int t1, t3, t4;
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd2;
        step();
        wr_en = 1'b0;
        start = 4'b0010;
        t1 = next_strobe(2);
        push_tick(1, t1); push_tick(1, t1 + 8);
        step();
        start = '0;
        run_to(t1 + 1);
        // Mid-period rewrite: current period finishes on the old count
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd5;
        t3 = t1 + 8 + 20;
        push_tick(1, t3);
        step();
        wr_en = 1'b0;
        run_to(t3 + 1);
        checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL rewrite_busy: got %b want 1", busy[1]); end
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd0;
        t4 = t3 + 20;
        push_tick(1, t4);
        step();
        wr_en = 1'b0;
        run_to(t4);
        checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL rewrite_zero_busy: got %b want 0", busy[1]); end
        run_to(cyc + 30);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rewrite_missing: %0d ticks outstanding, want 0", exp_q.size()); end
    endtask

    task automatic test_en_pause_clr();
        int a0, t3_last, t3_next;
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd1;
        step();
        wr_ch = 2'd3; wr_div = 8'd2;
        step();
        wr_en = 1'b0;
        start = 4'b1001;
        a0 = next_strobe(1);
        push_tick(0, a0); push_tick(0, a0 + 4); push_tick(3, a0 + 4);
        step();
        start = '0;
        run_to(a0 + 5);
        en = 1'b0;
        run_to(a0 + 12);
        checks++; if (busy !== 4'b1001) begin errors++; $display("FAIL pause_busy: got %b want 1001", busy); end
        en = 1'b1;
        push_tick(0, next_strobe(1));
        push_tick(0, next_strobe(2));
        t3_last = next_strobe(2);
        push_tick(3, t3_last);
        t3_next = t3_last + 8;
        run_to(t3_last + 1);
        // Start and stop together while running: stop wins
        start = 4'b0001; stop = 4'b0001;
        step();
        start = '0; stop = '0;
        checks++; if (busy !== 4'b1000) begin errors++; $display("FAIL start_stop_run: got %b want 1000", busy); end
        // Start and stop together while idle: no start
        start = 4'b0001; stop = 4'b0001;
        step();
        start = '0; stop = '0;
        checks++; if (busy !== 4'b1000) begin errors++; $display("FAIL start_stop_idle: got %b want 1000", busy); end
        run_to(t3_next - 1);
        // clr lands on the edge where ch3 would have expired
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (tick !== 4'b0000) begin errors++; $display("FAIL clr_tick: got %b want 0000", tick); end
        checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL clr_busy: got %b want 0000", busy); end
        run_to(cyc + 20);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL pause_missing: %0d ticks outstanding, want 0", exp_q.size()); end
    endtask

`ifdef TICK_SCHED_ONESHOT_EN
    task automatic test_oneshot();
        int t1;
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd2;
        step();
        wr_en = 1'b0;
        start = 4'b0010; oneshot = 4'b0010;
        t1 = next_strobe(2);
        push_tick(1, t1);
        step();
        start = '0; oneshot = '0;
        run_to(t1);
        checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL oneshot_busy: got %b want 0", busy[1]); end
        run_to(cyc + 20);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL oneshot_missing: %0d ticks outstanding, want 0", exp_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_cfg_err();
        test_periodic();
        test_rewrite();
        test_en_pause_clr();
`ifdef TICK_SCHED_ONESHOT_EN
        test_oneshot();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
